// File: rtl/alu_multicycle_if.sv
// Request/result bundle between the register-file controller (master) and the
// multicycle ALU (slave).
interface alu_multicycle_if #(
  parameter int OPER_WIDTH    = 8,
  parameter int ALU_FUN_WIDTH = 4
);
  logic                      ALU_EN;
  logic [OPER_WIDTH-1:0]     A;
  logic [OPER_WIDTH-1:0]     B;
  logic [ALU_FUN_WIDTH-1:0]  ALU_FUN;
  logic [2*OPER_WIDTH-1:0]   ALU_OUT;
  logic                      OUT_Valid;
  logic                      BUSY;
  logic                      DIV_ZERO;

  modport master (
    output ALU_EN, A, B, ALU_FUN,
    input  ALU_OUT, OUT_Valid, BUSY, DIV_ZERO
  );

  modport slave (
    input  ALU_EN, A, B, ALU_FUN,
    output ALU_OUT, OUT_Valid, BUSY, DIV_ZERO
  );
endinterface

// File: rtl/alu_multicycle.sv
// Register-output ALU: single-cycle ops plus an iterative restoring divider
// that returns {remainder, quotient} after OPER_WIDTH steps.
module alu_multicycle #(
  parameter int OPER_WIDTH    = 8,
  parameter int ALU_FUN_WIDTH = 4
) (
  input  logic CLK,
  input  logic RST,
  alu_multicycle_if.slave alu_bus
);

  localparam int OUT_WIDTH = 2 * OPER_WIDTH;
  localparam int CNT_WIDTH = $clog2(OPER_WIDTH + 1);

  localparam logic [ALU_FUN_WIDTH-1:0] FUN_ADD  = ALU_FUN_WIDTH'(0);
  localparam logic [ALU_FUN_WIDTH-1:0] FUN_SUB  = ALU_FUN_WIDTH'(1);
  localparam logic [ALU_FUN_WIDTH-1:0] FUN_MUL  = ALU_FUN_WIDTH'(2);
  localparam logic [ALU_FUN_WIDTH-1:0] FUN_DIV  = ALU_FUN_WIDTH'(3);
  localparam logic [ALU_FUN_WIDTH-1:0] FUN_AND  = ALU_FUN_WIDTH'(4);
  localparam logic [ALU_FUN_WIDTH-1:0] FUN_OR   = ALU_FUN_WIDTH'(5);
  localparam logic [ALU_FUN_WIDTH-1:0] FUN_NAND = ALU_FUN_WIDTH'(6);
  localparam logic [ALU_FUN_WIDTH-1:0] FUN_NOR  = ALU_FUN_WIDTH'(7);
  localparam logic [ALU_FUN_WIDTH-1:0] FUN_XOR  = ALU_FUN_WIDTH'(8);
  localparam logic [ALU_FUN_WIDTH-1:0] FUN_XNOR = ALU_FUN_WIDTH'(9);
  localparam logic [ALU_FUN_WIDTH-1:0] FUN_EQ   = ALU_FUN_WIDTH'(10);
  localparam logic [ALU_FUN_WIDTH-1:0] FUN_GT   = ALU_FUN_WIDTH'(11);
  localparam logic [ALU_FUN_WIDTH-1:0] FUN_LT   = ALU_FUN_WIDTH'(12);
  localparam logic [ALU_FUN_WIDTH-1:0] FUN_SHR  = ALU_FUN_WIDTH'(13);
  localparam logic [ALU_FUN_WIDTH-1:0] FUN_SHL  = ALU_FUN_WIDTH'(14);

  typedef enum logic {IDLE, DIV} state_t;

  state_t                 state_q, state_d;
  logic [OUT_WIDTH-1:0]   alu_out_q, alu_out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   div_zero_q, div_zero_d;
  logic [OPER_WIDTH-1:0]  dividend_q, dividend_d;
  logic [OPER_WIDTH-1:0]  divisor_q, divisor_d;
  logic [OPER_WIDTH:0]    rem_q, rem_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;

  logic [OUT_WIDTH-1:0]   op_result;
  logic [OPER_WIDTH+1:0]  shifted;
  logic [OPER_WIDTH+1:0]  trial;
  logic                   q_bit;

  // Passing through a narrow formal keeps bitwise inversions at OPER_WIDTH bits.
  function automatic logic [OUT_WIDTH-1:0] zext(input logic [OPER_WIDTH-1:0] v);
    return {{OPER_WIDTH{1'b0}}, v};
  endfunction

  always_comb begin
    op_result = '0;
    case (alu_bus.ALU_FUN)
      FUN_ADD:  op_result = OUT_WIDTH'(alu_bus.A) + OUT_WIDTH'(alu_bus.B);
      FUN_SUB:  op_result = OUT_WIDTH'(alu_bus.A) - OUT_WIDTH'(alu_bus.B);
      FUN_MUL:  op_result = OUT_WIDTH'(alu_bus.A) * OUT_WIDTH'(alu_bus.B);
      FUN_AND:  op_result = zext(alu_bus.A & alu_bus.B);
      FUN_OR:   op_result = zext(alu_bus.A | alu_bus.B);
      FUN_NAND: op_result = zext(~(alu_bus.A & alu_bus.B));
      FUN_NOR:  op_result = zext(~(alu_bus.A | alu_bus.B));
      FUN_XOR:  op_result = zext(alu_bus.A ^ alu_bus.B);
      FUN_XNOR: op_result = zext(~(alu_bus.A ^ alu_bus.B));
      FUN_EQ:   op_result = (alu_bus.A == alu_bus.B) ? OUT_WIDTH'(1) : '0;
      FUN_GT:   op_result = (alu_bus.A >  alu_bus.B) ? OUT_WIDTH'(2) : '0;
      FUN_LT:   op_result = (alu_bus.A <  alu_bus.B) ? OUT_WIDTH'(3) : '0;
      FUN_SHR:  op_result = zext(alu_bus.A >> 1);
      FUN_SHL:  op_result = {{(OPER_WIDTH-1){1'b0}}, alu_bus.A, 1'b0};
      default:  op_result = '0;
    endcase
  end

  // One restoring step: the quotient shifts into the dividend register as
  // dividend bits shift out into the partial remainder.
  always_comb begin
    shifted = {rem_q, dividend_q[OPER_WIDTH-1]};
    trial   = shifted - {2'b00, divisor_q};
    q_bit   = ~trial[OPER_WIDTH+1];
  end

  always_comb begin
    state_d     = state_q;
    alu_out_d   = alu_out_q;
    out_valid_d = 1'b0;
    div_zero_d  = div_zero_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    count_d     = count_q;
    case (state_q)
      IDLE: begin
        if (alu_bus.ALU_EN) begin
          if (alu_bus.ALU_FUN == FUN_DIV) begin
            if (alu_bus.B == '0) begin
              alu_out_d   = '0;
              div_zero_d  = 1'b1;
              out_valid_d = 1'b1;
            end else begin
              dividend_d = alu_bus.A;
              divisor_d  = alu_bus.B;
              rem_d      = '0;
              count_d    = '0;
              state_d    = DIV;
            end
          end else begin
            alu_out_d   = op_result;
            div_zero_d  = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      DIV: begin
        rem_d      = q_bit ? trial[OPER_WIDTH:0] : shifted[OPER_WIDTH:0];
        dividend_d = {dividend_q[OPER_WIDTH-2:0], q_bit};
        count_d    = count_q + CNT_WIDTH'(1);
        if (count_q == CNT_WIDTH'(OPER_WIDTH - 1)) begin
          alu_out_d   = {rem_d[OPER_WIDTH-1:0], dividend_d};
          div_zero_d  = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      alu_out_q   <= '0;
      out_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      alu_out_q   <= alu_out_d;
      out_valid_q <= out_valid_d;
      div_zero_q  <= div_zero_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      count_q     <= count_d;
    end
  end

  assign alu_bus.ALU_OUT   = alu_out_q;
  assign alu_bus.OUT_Valid = out_valid_q;
  assign alu_bus.DIV_ZERO  = div_zero_q;
  assign alu_bus.BUSY      = (state_q == DIV);

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: expected results are queued at issue
// and compared, with their arrival cycle, whenever OUT_Valid pulses.
module tb_alu_multicycle;

  localparam int W = 8;

  typedef struct {
    logic [15:0] out;
    logic        dz;
    int          cyc;
  } exp_t;

  logic CLK;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_left = 0;
  logic [15:0] last_out = '0;
  logic        last_dz = 1'b0;
  exp_t exp_q[$];
  exp_t mon_entry;

  alu_multicycle_if #(.OPER_WIDTH(W), .ALU_FUN_WIDTH(4)) alu_bus();

  alu_multicycle #(.OPER_WIDTH(W), .ALU_FUN_WIDTH(4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .alu_bus (alu_bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d",
               tag, observed, expected, cyc);
    end
  endtask

  // Independent reference: {div_zero, result} for one request.
  function automatic logic [16:0] modelAlu(input logic [3:0] fun,
                                           input logic [7:0] a, input logic [7:0] b);
    int ia = a;
    int ib = b;
    logic [15:0] r = '0;
    logic dz = 1'b0;
    case (fun)
      4'd0:  r = 16'(ia + ib);
      4'd1:  r = 16'(ia - ib);
      4'd2:  r = 16'(ia * ib);
      4'd3:  if (ib == 0) dz = 1'b1; else r = 16'(((ia % ib) * 256) + (ia / ib));
      4'd4:  r = {8'h00, a & b};
      4'd5:  r = {8'h00, a | b};
      4'd6:  r = {8'h00, ~(a & b)};
      4'd7:  r = {8'h00, ~(a | b)};
      4'd8:  r = {8'h00, a ^ b};
      4'd9:  r = {8'h00, ~(a ^ b)};
      4'd10: r = (ia == ib) ? 16'd1 : 16'd0;
      4'd11: r = (ia > ib) ? 16'd2 : 16'd0;
      4'd12: r = (ia < ib) ? 16'd3 : 16'd0;
      4'd13: r = 16'(ia / 2);
      4'd14: r = 16'(ia * 2);
      default: r = 16'd0;
    endcase
    return {dz, r};
  endfunction

  // One clock of stimulus; the bench tracks its own notion of busy so that
  // requests presented during a division are expected to be dropped.
  task automatic applyStimulus(input logic en, input logic [3:0] fun,
                               input logic [7:0] a, input logic [7:0] b);
    logic [16:0] r;
    exp_t e;
    @(negedge CLK);
    checkOutput("busy", {31'd0, alu_bus.BUSY}, {31'd0, busy_left != 0});
    alu_bus.ALU_EN  = en;
    alu_bus.ALU_FUN = fun;
    alu_bus.A       = a;
    alu_bus.B       = b;
    if (en && busy_left == 0) begin
      r = modelAlu(fun, a, b);
      e.out = r[15:0];
      e.dz  = r[16];
      e.cyc = cyc + 1 + ((fun == 4'd3 && b != 0) ? W : 0);
      exp_q.push_back(e);
      if (fun == 4'd3 && b != 0) busy_left = W;
    end else if (busy_left > 0) begin
      busy_left--;
    end
  endtask

  task automatic pulseReset();
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("arst_out",   {16'd0, alu_bus.ALU_OUT}, 32'd0);
    checkOutput("arst_valid", {31'd0, alu_bus.OUT_Valid}, 32'd0);
    checkOutput("arst_busy",  {31'd0, alu_bus.BUSY}, 32'd0);
    checkOutput("arst_dz",    {31'd0, alu_bus.DIV_ZERO}, 32'd0);
    exp_q.delete();
    busy_left = 0;
    last_out  = '0;
    last_dz   = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (alu_bus.OUT_Valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", {31'd0, alu_bus.OUT_Valid}, 32'd0);
      end else begin
        mon_entry = exp_q.pop_front();
        checkOutput("alu_out",     {16'd0, alu_bus.ALU_OUT}, {16'd0, mon_entry.out});
        checkOutput("div_zero",    {31'd0, alu_bus.DIV_ZERO}, {31'd0, mon_entry.dz});
        checkOutput("valid_cycle", cyc, mon_entry.cyc);
        last_out = mon_entry.out;
        last_dz  = mon_entry.dz;
      end
    end else begin
      checkOutput("hold_out", {16'd0, alu_bus.ALU_OUT}, {16'd0, last_out});
      checkOutput("hold_dz",  {31'd0, alu_bus.DIV_ZERO}, {31'd0, last_dz});
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checkOutput("missing_valid", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST = 1'b1;
    alu_bus.ALU_EN  = 1'b0;
    alu_bus.ALU_FUN = '0;
    alu_bus.A       = '0;
    alu_bus.B       = '0;
    repeat (2) @(negedge CLK);
    checkOutput("reset_out",   {16'd0, alu_bus.ALU_OUT}, 32'd0);
    checkOutput("reset_valid", {31'd0, alu_bus.OUT_Valid}, 32'd0);
    checkOutput("reset_busy",  {31'd0, alu_bus.BUSY}, 32'd0);
    checkOutput("reset_dz",    {31'd0, alu_bus.DIV_ZERO}, 32'd0);
    RST = 1'b0;

    // Back-to-back single-cycle ops.
    applyStimulus(1, 4'd0, 8'd200, 8'd100);
    applyStimulus(1, 4'd1, 8'd5, 8'd7);
    applyStimulus(1, 4'd4, 8'hC3, 8'h5A);
    applyStimulus(1, 4'd5, 8'hC3, 8'h5A);
    applyStimulus(1, 4'd6, 8'hC3, 8'h5A);
    applyStimulus(1, 4'd7, 8'hC3, 8'h5A);
    applyStimulus(1, 4'd8, 8'hC3, 8'h5A);
    applyStimulus(1, 4'd9, 8'hC3, 8'h5A);
    applyStimulus(1, 4'd11, 8'd3, 8'd9);
    applyStimulus(1, 4'd12, 8'd3, 8'd9);
    applyStimulus(1, 4'd13, 8'hF3, 8'd0);
    applyStimulus(0, 4'd0, 8'd0, 8'd0);

    // Division with requests hammered during every busy cycle.
    applyStimulus(1, 4'd3, 8'd200, 8'd7);
    for (int i = 0; i < W; i++) applyStimulus(1, 4'd0, 8'(i), 8'd1);
    applyStimulus(1, 4'd0, 8'd40, 8'd2);
    applyStimulus(0, 4'd0, 8'd0, 8'd0);

    // Divide-by-zero, then the flag must clear on the next result.
    applyStimulus(1, 4'd3, 8'd5, 8'd0);
    applyStimulus(1, 4'd0, 8'd1, 8'd1);
    applyStimulus(1, 4'd3, 8'd3, 8'd200);
    for (int i = 0; i < W; i++) applyStimulus(0, 4'd0, 8'd0, 8'd0);
    applyStimulus(1, 4'd3, 8'd255, 8'd1);
    for (int i = 0; i < W; i++) applyStimulus(0, 4'd0, 8'd0, 8'd0);

    // Abort a division with reset.
    applyStimulus(1, 4'd3, 8'd255, 8'd3);
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'd0, 8'd0, 8'd0);
    pulseReset();
    applyStimulus(1, 4'd11, 8'd9, 8'd3);

    // Mixed sweep, including the shifted-out MSB and the zero function.
    applyStimulus(1, 4'd14, 8'h81, 8'd0);
    applyStimulus(1, 4'd10, 8'h55, 8'h55);
    applyStimulus(1, 4'd15, 8'd12, 8'd34);
    applyStimulus(1, 4'd2, 8'd255, 8'd255);
    applyStimulus(1, 4'd10, 8'h55, 8'h54);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] rb;
      rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                    8'($urandom), rb);
    end
    applyStimulus(0, 4'd0, 8'd0, 8'd0);

    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge CLK);
    @(negedge CLK);
    checkOutput("drain_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
Parametrised successor to the team's single-cycle register-output ALU. It keeps the same 4-bit function map. Division is replaced by an iterative restoring divider that returns both quotient and remainder and flags divide-by-zero. A BUSY/OUT_Valid handshake lets the register-file controller issue operations back-to-back without waiting on worst-case combinational divide timing.

Parameters:
OPER_WIDTH, 8, operand width in bits (>=2)
OUT_WIDTH, 2*OPER_WIDTH, result width; fixed relation, not to be overridden independently
ALU_FUN_WIDTH, 4, function-select width

Ports:
CLK  input  1  single clock, rising-edge
RST  input  1  reset, asynchronous, active-high
ALU_EN  input  1  operation request; sampled only when BUSY=0
A  input  OPER_WIDTH  operand A, unsigned
B  input  OPER_WIDTH  operand B, unsigned
ALU_FUN  input  ALU_FUN_WIDTH  function select
ALU_OUT  output  OUT_WIDTH  registered result; holds last value between results
OUT_Valid  output  1  one-cycle pulse, ALU_OUT/DIV_ZERO are new
BUSY  output  1  high while a division is iterating; requests ignored
DIV_ZERO  output  1  registered with each result; 1 only for divide with B=0

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: ALU_OUT=0, OUT_Valid=0, BUSY=0, DIV_ZERO=0, FSM=IDLE, internal divider regs=0.
- RST asserted mid-division aborts immediately. No result is produced for the aborted operation.
- FSM states: IDLE and DIV.
- Accept condition: ALU_EN=1 in IDLE at edge k. ALU_EN in DIV is ignored, with no queueing.
- Non-divide ops, latency 1: at edge k ALU_OUT is loaded, OUT_Valid=1 for the following cycle, DIV_ZERO=0. FSM stays in IDLE, so back-to-back issue every cycle is allowed.
- Function map (results zero-extended to OUT_WIDTH):
  - 0000 A+B, carry kept in bit OPER_WIDTH
  - 0001 A-B, two's-complement wrap modulo 2^OUT_WIDTH
  - 0010 A*B, full product
  - 0011 divide, see below
  - 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 XOR, 1001 XNOR
    - bitwise on OPER_WIDTH bits; upper half = 0
  - 1010 compare: 1 if A==B, else 0
  - 1011 compare: 2 if A>B, else 0
  - 1100 compare: 3 if A<B, else 0
  - 1101 A>>1
  - 1110 A<<1, bit OPER_WIDTH keeps the shifted-out MSB
  - 1111 ALU_OUT=0, OUT_Valid still pulses
- Divide, B!=0:
  - at edge k, latch A and B, clear remainder, count=0, go to DIV; BUSY=1 from edge k.
  - each subsequent edge performs one restoring step, MSB first. Remainder reg is OPER_WIDTH+1 bits.
  - at edge k+OPER_WIDTH: ALU_OUT={remainder, quotient} (remainder in upper half), OUT_Valid=1, DIV_ZERO=0, BUSY=0, FSM=IDLE.
  - a new request is accepted at edge k+OPER_WIDTH+1 at the earliest.
- Divide, B=0: no iteration, handled as latency 1. At edge k, ALU_OUT=0 and DIV_ZERO=1; OUT_Valid pulses; FSM stays in IDLE.
- OUT_Valid is never high for two cycles from one request.
- ALU_OUT and DIV_ZERO change only when OUT_Valid is asserted (or on reset).
- A, B and ALU_FUN may change freely after the accept edge. The divider uses latched copies.

Test Plan (OPER_WIDTH=8):
1. After reset, ALU_EN=1, FUN=0000, A=200, B=100 -> next cycle ALU_OUT=16'd300, OUT_Valid high exactly 1 cycle. Then FUN=0001, A=5, B=7 on the very next cycle -> ALU_OUT=16'hFFFE.
2. FUN=0011, A=200, B=7 -> BUSY=1 for 8 cycles. OUT_Valid on the 8th edge after accept with ALU_OUT=16'h041C (rem 4, quot 28), DIV_ZERO=0.
3. During scenario 2, drive ALU_EN=1, FUN=0000 on cycles 2-7 -> ignored: a single OUT_Valid, ALU_OUT=16'h041C. An add issued on the cycle after BUSY falls is accepted.
4. FUN=0011, A=5, B=0 -> 1-cycle latency, ALU_OUT=0, DIV_ZERO=1, BUSY never high. A following add A=1, B=1 gives ALU_OUT=2, DIV_ZERO=0.
5. Start divide 255/3, assert RST asynchronously at 4th BUSY cycle -> all outputs 0 immediately, no OUT_Valid after release. Then FUN=1011, A=9, B=3 -> ALU_OUT=2.
6. Mixed sweep: FUN=1110, A=8'h81 -> 16'h0102; FUN=1010, A=B=8'h55 -> 1; FUN=1111 -> ALU_OUT=0 with OUT_Valid=1; FUN=0010, A=B=255 -> 16'hFE01.
